// File: rtl/seq_bitcount_pkg.sv
// Shared encodings for the sequential bit-counting unit.
package seq_bitcount_pkg;

  typedef enum logic [1:0] {
    MODE_POP  = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_CLZ  = 2'b10,
    MODE_CLO  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_bitcount_chunk_count.sv
// Combinational counter for one chunk: number of ones plus leading-zero and
// leading-one run lengths measured from the chunk MSB.
module chunk_count
  import seq_bitcount_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]               bits,
  output logic [$clog2(CHUNK+1)-1:0]     ones,
  output logic [$clog2(CHUNK+1)-1:0]     lead_zeros,
  output logic [$clog2(CHUNK+1)-1:0]     lead_ones
);

  localparam int KW = $clog2(CHUNK+1);

  always_comb begin
    logic run0;
    logic run1;
    ones       = '0;
    lead_zeros = '0;
    lead_ones  = '0;
    run0       = 1'b1;
    run1       = 1'b1;
    // Run flags stay high only while every bit seen so far matches the target.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      run0 = run0 & ~bits[i];
      run1 = run1 &  bits[i];
      if (bits[i]) ones = ones + KW'(1);
      if (run0) lead_zeros = lead_zeros + KW'(1);
      if (run1) lead_ones = lead_ones + KW'(1);
    end
  end

endmodule

// File: rtl/seq_bitcount.sv
// Multi-cycle POP/ZERO/CLZ/CLO counter, CHUNK bits per cycle, MSB chunk first.
// Define SEQ_BITCOUNT_EARLY_EXIT_EN to finish CLZ/CLO as soon as the run ends.
module seq_bitcount
  import seq_bitcount_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [1:0]                   in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_count
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(WIDTH+1);
  localparam int KW = $clog2(CHUNK+1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("seq_bitcount: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end
  endgenerate

  state_t            state_reg,   state_next;
  mode_t             mode_reg,    mode_next;
  logic [WIDTH-1:0]  shift_reg,   shift_next;
  logic [CW-1:0]     acc_reg,     acc_next;
  logic [CW-1:0]     count_reg,   count_next;
  logic [IW-1:0]     idx_reg,     idx_next;
  logic              stopped_reg, stopped_next;

  logic [KW-1:0]     ones;
  logic [KW-1:0]     lead_zeros;
  logic [KW-1:0]     lead_ones;
  logic [KW-1:0]     lead;
  logic [KW-1:0]     add_val;
  logic [CW-1:0]     acc_sum;
  logic              is_lead_mode;
  logic              stop_hit;
  logic              last_chunk;
  logic              early_exit;

  chunk_count #(.CHUNK(CHUNK)) u_chunk (
    .bits       (shift_reg[WIDTH-1 -: CHUNK]),
    .ones       (ones),
    .lead_zeros (lead_zeros),
    .lead_ones  (lead_ones)
  );

  always_comb begin
    is_lead_mode = (mode_reg == MODE_CLZ) || (mode_reg == MODE_CLO);
    lead         = (mode_reg == MODE_CLZ) ? lead_zeros : lead_ones;
    // A partial run inside this chunk means the leading run ends here.
    stop_hit     = is_lead_mode && !stopped_reg && (lead != KW'(CHUNK));
    last_chunk   = (idx_reg == IW'(N - 1));
    case (mode_reg)
      MODE_POP:  add_val = ones;
      MODE_ZERO: add_val = KW'(CHUNK) - ones;
      default:   add_val = stopped_reg ? '0 : lead;
    endcase
    acc_sum = acc_reg + CW'(add_val);
  end

`ifdef SEQ_BITCOUNT_EARLY_EXIT_EN
  assign early_exit = stop_hit;
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    shift_next   = shift_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    idx_next     = idx_reg;
    stopped_next = stopped_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next   = ST_RUN;
          mode_next    = mode_t'(in_mode);
          shift_next   = in_data;
          acc_next     = '0;
          idx_next     = '0;
          stopped_next = 1'b0;
        end
      end
      ST_RUN: begin
        shift_next   = shift_reg << CHUNK;
        idx_next     = idx_reg + IW'(1);
        acc_next     = acc_sum;
        stopped_next = stopped_reg | stop_hit;
        if (last_chunk || early_exit) begin
          state_next = ST_DONE;
          count_next = acc_sum;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= MODE_POP;
      shift_reg   <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      idx_reg     <= '0;
      stopped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      shift_reg   <= shift_next;
      acc_reg     <= acc_next;
      count_reg   <= count_next;
      idx_reg     <= idx_next;
      stopped_reg <= stopped_next;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign out_count = count_reg;

endmodule
